addsub_pipe: RTL and testbench
==============================

// Module: addsub_pipe
// PURPOSE
//   Parametrised, pipelined two's-complement adder/subtractor; successor to the 8-bit ripple add/sub.
//   Splits a WIDTH-bit add/sub into CHUNK-bit slices, one slice per stage, with a registered carry between stages.
//   Has a valid/ready handshake on both sides and produces carry/borrow, overflow, zero and negative flags.
//   Sits between operand sources and the datapath; throughput is 1 op/cycle, latency is STAGES cycles.
// PARAMETERS
//   WIDTH  16  operand/result width in bits; must be a multiple of CHUNK
//   CHUNK  4   bits added per pipeline stage; STAGES = WIDTH/CHUNK (min 1)
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      operands a/b/sub are valid this cycle
//   in_ready   out  1      block accepts an op this cycle
//   a          in   WIDTH  minuend / augend
//   b          in   WIDTH  subtrahend / addend
//   sub        in   1      1 = a-b (b inverted, carry-in 1); 0 = a+b
//   out_valid  out  1      s and flags are valid
//   out_ready  in   1      downstream accepts the result
//   s          out  WIDTH  result
//   cout       out  1      sub ^ carry-out of MSB: add = unsigned carry; sub = borrow (a<b unsigned)
//   ovf        out  1      signed overflow = carry into MSB ^ carry out of MSB
//   zero       out  1      s == 0 (after saturation, if enabled)
//   neg        out  1      s[WIDTH-1] (after saturation, if enabled)
// BEHAVIOUR
//   Reset (async, rst_n=0): all stage valids = 0; out_valid=0; s=0; cout=ovf=zero=neg=0. in_ready is 1 while out_ready=1.
//   advance = !out_valid | out_ready; in_ready = advance (combinational). The whole pipe shifts only on advance.
//   Accept: in_valid & in_ready. Stage 0 adds a[CHUNK-1:0] + (b^{sub})[CHUNK-1:0] + sub.
//     Stage k adds slice k with the registered carry from stage k-1.
//     Unconsumed upper operand slices and lower result slices ride the pipe (skew registers).
//   Latency: the result appears with out_valid=1 exactly STAGES cycles after acceptance, provided there is no stall.
//   Stall: out_valid & !out_ready freezes every stage register; s/flags hold stable; in_ready=0.
//   Bubbles: an invalid beat propagates as a bubble; bubbles are not collapsed.
//   Outputs are registered (final stage regs). No combinational path from a/b to s.
//   Simultaneous accept + drain in one cycle: both happen; full throughput is sustained.
//   Reset mid-operation: all in-flight ops are discarded and none appear after reset release.
//   Width rules: arithmetic per slice is CHUNK+1 bits. The MSB slice also records the carry into bit WIDTH-1 for ovf.
// CONFIGURATION
//   ADDSUB_SAT_EN defined: on ovf=1, s clamps to the signed limit:
//     positive overflow -> {0,{WIDTH-1{1}}}; negative overflow -> {1,{WIDTH-1{0}}}.
//     ovf and cout still report the raw condition; zero/neg reflect the clamped s.
//   Not defined: s wraps modulo 2^WIDTH; no clamp logic is present.
// STRUCTURE
//   Package addsub_pkg:
//     flag struct {cout, ovf, zero, neg};
//     function/localparam for STAGES = WIDTH/CHUNK;
//     signed-limit constants (SMAX/SMIN) as functions of WIDTH.
//   Sub-module addsub_slice: one CHUNK-bit add with carry-in, producing sum, carry-out and carry-into-MSB.
//     Purely combinational; addsub_pipe instantiates it STAGES times inside a generate loop and owns all registers.
//   Static check: elaboration error if WIDTH % CHUNK != 0 or CHUNK < 1.
// TESTING (WIDTH=16, CHUNK=4, STAGES=4)
//   Add: a=0x1234, b=0x0001, sub=0, out_ready=1 -> 4 cycles later s=0x1235, cout=0, ovf=0, zero=0, neg=0.
//   Sub borrow: a=0x0003, b=0x0005, sub=1 -> s=0xFFFE, cout=1, ovf=0, neg=1; a=b=0x00FF, sub=1 -> s=0, zero=1, cout=0.
//   Carry chain across all slices: a=0xFFFF, b=0x0001, sub=0 -> s=0x0000, cout=1, zero=1, ovf=0.
//   Overflow: a=0x7FFF, b=0x0001, sub=0 -> ovf=1; s=0x8000 (wrap), or s=0x7FFF, neg=0 with ADDSUB_SAT_EN.
//     a=0x8000, b=0x0001, sub=1 -> ovf=1; s=0x7FFF (wrap), or 0x8000 with ADDSUB_SAT_EN.
//   Back-to-back: 8 ops on consecutive cycles, out_ready held low for 3 cycles mid-stream
//     -> s/flags frozen during the stall, in_ready=0, all 8 results in order with no loss or duplication.
//   Reset: assert rst_n=0 with 3 ops in flight -> out_valid=0 immediately;
//     after release, no stale result appears before the next accepted op.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and helpers for the pipelined add/sub block.
// Provides the flag bundle, the stage-count helper and the signed limits used when
// the ADDSUB_SAT_EN macro enables saturation.
package addsub_pkg;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
        logic neg;
    } flags_t;

    // Upper bound on WIDTH supported by the limit helpers below.
    localparam int MAX_WIDTH = 1024;

    // Number of pipeline stages, one per CHUNK-bit slice (never less than one).
    function automatic int calc_stages(input int width, input int chunk);
        if (chunk < 1 || width < chunk) return 1;
        return width / chunk;
    endfunction

    // Largest positive two's-complement value of the given width.
    function automatic logic [MAX_WIDTH-1:0] smax(input int width);
        logic [MAX_WIDTH-1:0] one;
        one = MAX_WIDTH'(1);
        return (one << (width - 1)) - one;
    endfunction

    // Most negative two's-complement value of the given width.
    function automatic logic [MAX_WIDTH-1:0] smin(input int width);
        logic [MAX_WIDTH-1:0] one;
        one = MAX_WIDTH'(1);
        return one << (width - 1);
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// One CHUNK-bit slice of the add/sub chain: sum, carry-out and the carry into the
// slice's top bit (needed for signed overflow on the most significant slice).
// Purely combinational; the enclosing pipeline owns every register.
module addsub_slice
    import addsub_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign sum  = full[CHUNK-1:0];
    assign cout = full[CHUNK];

    // Carry into the top bit: with a single-bit slice that is simply the carry-in.
    if (CHUNK == 1) begin : g_c1
        assign cmsb = cin;
    end else begin : g_cn
        logic [CHUNK-1:0] low;
        assign low  = {1'b0, a[CHUNK-2:0]} + {1'b0, b[CHUNK-2:0]} + {{(CHUNK-1){1'b0}}, cin};
        assign cmsb = low[CHUNK-1];
    end

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor with valid/ready on both sides.
// One CHUNK-bit slice is resolved per stage; the carry between slices is registered.
// Operand bits not yet consumed and result bits already produced travel with the op.
// Optional macro ADDSUB_SAT_EN: clamp s to the signed limit on overflow
// (cout/ovf still report the raw condition, zero/neg follow the clamped s).
//
// Handshake: an op is accepted when in_valid & in_ready; a result is consumed when
// out_valid & out_ready. in_ready = !out_valid | out_ready, and the whole pipe moves
// only when in_ready is high, so a stalled output freezes every stage.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int STAGES = calc_stages(WIDTH, CHUNK);

    // Reject configurations that cannot be cut into whole slices.
    if (CHUNK < 1) begin : g_bad_chunk
        $error("addsub_pipe: CHUNK must be at least 1");
    end else if ((WIDTH < CHUNK) || ((WIDTH % CHUNK) != 0)) begin : g_bad_width
        $error("addsub_pipe: WIDTH must be a non-zero multiple of CHUNK");
    end

`ifdef ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] SMAX = WIDTH'(smax(WIDTH));
    localparam logic [WIDTH-1:0] SMIN = WIDTH'(smin(WIDTH));
`endif

    // Stage registers, index k holds the op after slice k has been resolved.
    logic [STAGES-1:0]            v_r;
    logic [STAGES-1:0]            carry_r;
    logic [STAGES-1:0]            sub_r;
    logic [STAGES-1:0][WIDTH-1:0] a_r;
    logic [STAGES-1:0][WIDTH-1:0] bx_r;
    logic [STAGES-1:0][WIDTH-1:0] s_r;
    flags_t                       flags_r;

    // Per-stage inputs to the slice adders and their results.
    logic [STAGES-1:0]            v_in;
    logic [STAGES-1:0]            c_in;
    logic [STAGES-1:0]            sub_in;
    logic [STAGES-1:0][WIDTH-1:0] a_in;
    logic [STAGES-1:0][WIDTH-1:0] bx_in;
    logic [STAGES-1:0][WIDTH-1:0] s_in;
    logic [STAGES-1:0][CHUNK-1:0] sum_w;
    logic [STAGES-1:0]            co_w;
    logic [STAGES-1:0]            cm_w;

    logic [STAGES-1:0][WIDTH-1:0] s_ld;
    logic [WIDTH-1:0]             raw;
    logic [WIDTH-1:0]             s_fin;
    flags_t                       flags_nx;
    logic                         advance;

    assign advance  = !v_r[STAGES-1] || out_ready;
    assign in_ready = advance;

    // Stage 0 takes the ports (b pre-inverted for subtract); later stages take the previous register.
    always_comb begin
        v_in[0]   = in_valid;
        c_in[0]   = sub;
        sub_in[0] = sub;
        a_in[0]   = a;
        bx_in[0]  = b ^ {WIDTH{sub}};
        s_in[0]   = '0;
        for (int k = 1; k < STAGES; k++) begin
            v_in[k]   = v_r[k-1];
            c_in[k]   = carry_r[k-1];
            sub_in[k] = sub_r[k-1];
            a_in[k]   = a_r[k-1];
            bx_in[k]  = bx_r[k-1];
            s_in[k]   = s_r[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        addsub_slice #(.CHUNK(CHUNK)) u_slice (
            .a    (a_in[k][k*CHUNK +: CHUNK]),
            .b    (bx_in[k][k*CHUNK +: CHUNK]),
            .cin  (c_in[k]),
            .sum  (sum_w[k]),
            .cout (co_w[k]),
            .cmsb (cm_w[k])
        );
    end

    // Merge each slice sum into its partial result; derive flags (and clamp) on the last stage.
    always_comb begin
        s_ld     = '0;
        flags_nx = '0;
        for (int k = 0; k < STAGES; k++) begin
            s_ld[k] = s_in[k];
            s_ld[k][k*CHUNK +: CHUNK] = sum_w[k];
        end
        raw           = s_ld[STAGES-1];
        flags_nx.cout = sub_in[STAGES-1] ^ co_w[STAGES-1];
        flags_nx.ovf  = cm_w[STAGES-1] ^ co_w[STAGES-1];
        s_fin         = raw;
`ifdef ADDSUB_SAT_EN
        // A negative-looking raw result on overflow means the true value was too positive.
        if (flags_nx.ovf) begin
            s_fin = raw[WIDTH-1] ? SMAX : SMIN;
        end
`endif
        s_ld[STAGES-1] = s_fin;
        flags_nx.zero  = (s_fin == '0);
        flags_nx.neg   = s_fin[WIDTH-1];
    end

    // Shift the whole pipe on advance; reset discards every op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_r     <= '0;
            carry_r <= '0;
            sub_r   <= '0;
            a_r     <= '0;
            bx_r    <= '0;
            s_r     <= '0;
            flags_r <= '0;
        end else if (advance) begin
            v_r     <= v_in;
            carry_r <= co_w;
            sub_r   <= sub_in;
            a_r     <= a_in;
            bx_r    <= bx_in;
            s_r     <= s_ld;
            flags_r <= flags_nx;
        end
    end

    assign out_valid = v_r[STAGES-1];
    assign s         = s_r[STAGES-1];
    assign cout      = flags_r.cout;
    assign ovf       = flags_r.ovf;
    assign zero      = flags_r.zero;
    assign neg       = flags_r.neg;

    // Last-stage operand copies and the carry-into-top of lower slices have no consumer.
    logic unused_bits;
    assign unused_bits = ^{a_r[STAGES-1], bx_r[STAGES-1], carry_r[STAGES-1],
                           sub_r[STAGES-1], cm_w};

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe (WIDTH=16, CHUNK=4). Honors ADDSUB_SAT_EN.
module tb_addsub_pipe;

    localparam int W      = 16;
    localparam int C      = 4;
    localparam int STAGES = W / C;
    localparam int RW     = W + 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          sub;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  s;
    logic          cout;
    logic          ovf;
    logic          zero;
    logic          neg;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_out  = 0;

    logic [RW-1:0] exp_q[$];

    addsub_pipe #(.WIDTH(W), .CHUNK(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .neg       (neg)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Reference: result {s, cout, ovf, zero, neg} from integer arithmetic.
    function automatic logic [RW-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic sb);
        logic [W:0]   u;
        logic [W-1:0] res;
        logic         c;
        logic         o;
        int           r;
        if (!sb) begin
            u = {1'b0, x} + {1'b0, y};
            c = u[W];
            r = int'($signed(x)) + int'($signed(y));
        end else begin
            u = {1'b0, x} - {1'b0, y};
            c = (x < y);
            r = int'($signed(x)) - int'($signed(y));
        end
        res = u[W-1:0];
        o   = (r > ((1 << (W - 1)) - 1)) || (r < -(1 << (W - 1)));
`ifdef ADDSUB_SAT_EN
        if (o) res = (r > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`endif
        return {res, c, o, (res == '0), res[W-1]};
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            4:       return 16'h0001;
            default: return W'($urandom);
        endcase
    endfunction

    // driver: one clock of stimulus; reports acceptance and the outputs seen mid-cycle
    task automatic step(input logic iv, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic sb, input logic ordy,
                        output logic acc, output logic ov, output logic [RW-1:0] res);
        in_valid  = iv;
        a         = x;
        b         = y;
        sub       = sb;
        out_ready = ordy;
        @(negedge clk);
        acc = iv && in_ready;
        ov  = out_valid;
        res = {s, cout, ovf, zero, neg};
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic acc, ov;
        logic [RW-1:0] res;
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b1, acc, ov, res);
    endtask

    // directed op on an empty pipe: pins the model, the latency and the DUT result
    task automatic directed(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic sb, input logic [RW-1:0] lit);
        logic acc, ov, got;
        logic [RW-1:0] res;
        int lat;
        check({name, "_model"}, 32'(model(x, y, sb)), 32'(lit));
        step(1'b1, x, y, sb, 1'b1, acc, ov, res);
        check({name, "_accept"}, 32'(acc), 32'd1);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            step(1'b0, '0, '0, 1'b0, 1'b1, acc, ov, res);
            lat++;
            got = ov;
        end
        check({name, "_latency"}, 32'(lat), 32'(STAGES));
        check({name, "_dut"}, 32'(res), 32'(lit));
    endtask

    // scoreboard / compare process
    logic          stall_prev = 1'b0;
    logic [RW:0]   held;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            stall_prev = 1'b0;
            check("reset_out_valid", 32'(out_valid), 32'd0);
        end else begin
            if (stall_prev) begin
                check("stall_hold", 32'({out_valid, s, cout, ovf, zero, neg}), 32'(held));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_out: got out_valid=1 s=%0h required no pending result", s);
                end else begin
                    check("result", 32'({s, cout, ovf, zero, neg}), 32'(exp_q.pop_front()));
                    n_out++;
                end
            end
            if (out_valid && !out_ready) begin
                check("stall_in_ready", 32'(in_ready), 32'd0);
            end
            stall_prev = out_valid && !out_ready;
            held       = {out_valid, s, cout, ovf, zero, neg};
            if (in_valid && in_ready) exp_q.push_back(model(a, b, sub));
        end
    end

    initial begin
        logic acc, ov;
        logic [RW-1:0] res;
        logic [W-1:0]  ops_a[8];
        logic [W-1:0]  ops_b[8];
        logic          ops_s[8];
        int idx, cyc, base;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 32'({out_valid, s, cout, ovf, zero, neg}), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        idle(2);

        // directed vectors with hand-computed results
        directed("add",      16'h1234, 16'h0001, 1'b0, {16'h1235, 4'b0000});
        directed("sub_brw",  16'h0003, 16'h0005, 1'b1, {16'hFFFE, 4'b1001});
        directed("sub_zero", 16'h00FF, 16'h00FF, 1'b1, {16'h0000, 4'b0010});
        directed("carry",    16'hFFFF, 16'h0001, 1'b0, {16'h0000, 4'b1010});
`ifdef ADDSUB_SAT_EN
        directed("ovf_pos",  16'h7FFF, 16'h0001, 1'b0, {16'h7FFF, 4'b0100});
        directed("ovf_neg",  16'h8000, 16'h0001, 1'b1, {16'h8000, 4'b0101});
`else
        directed("ovf_pos",  16'h7FFF, 16'h0001, 1'b0, {16'h8000, 4'b0101});
        directed("ovf_neg",  16'h8000, 16'h0001, 1'b1, {16'h7FFF, 4'b0100});
`endif

        // back-to-back ops with a 3-cycle output stall mid-stream
        for (int i = 0; i < 8; i++) begin
            ops_a[i] = pick();
            ops_b[i] = pick();
            ops_s[i] = 1'($urandom_range(0, 1));
        end
        base = n_out;
        idx  = 0;
        cyc  = 0;
        while (idx < 8 && cyc < 40) begin
            step(1'b1, ops_a[idx], ops_b[idx], ops_s[idx], !(cyc >= 5 && cyc < 8), acc, ov, res);
            if (acc) idx++;
            cyc++;
        end
        check("b2b_accepted", 32'(idx), 32'd8);
        idle(STAGES + 4);
        check("b2b_results", 32'(n_out - base), 32'd8);

        // randomized traffic with bubbles and backpressure
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 9) < 7), pick(), pick(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0), acc, ov, res);
        end
        idle(STAGES + 4);
        check("random_drained", 32'(exp_q.size()), 32'd0);

        // reset with ops in flight
        for (int i = 0; i < 4; i++) step(1'b1, pick(), pick(), 1'b0, 1'b1, acc, ov, res);
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_s", 32'(s), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(10);
        check("post_reset_quiet", 32'(out_valid), 32'd0);
        directed("post_reset", 16'h0100, 16'h0200, 1'b0, {16'h0300, 4'b0000});
        idle(2);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
